mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the instruction-fetch port and the MEM-stage data port.
- Replaces the fixed single-cycle dual-port memory path with a request/acknowledge bus, so the slave can have variable latency.
- Arbitrates round-robin between the two ports, registers all responses and detects bus timeouts.
- Raises stall requests toward pipe_ctrl while either port waits.

Parameters:
- ADDR_WIDTH, 32, address width of ports and bus.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 64, cycles in a grant state without bus_ack_i before abort; 0 disables timeout.
- CNT_WIDTH, 8, timeout counter width; must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- inst_ce_i  in  1  fetch request level, held until inst_valid_o
- inst_addr_i  in  ADDR_WIDTH  fetch address (pc)
- inst_o  out  DATA_WIDTH  fetched instruction
- inst_valid_o  out  1  one-cycle completion pulse for fetch
- data_ce_i  in  1  data request level, held until data_valid_o
- data_we_i  in  1  1 = write, 0 = read
- data_addr_i  in  ADDR_WIDTH  data address
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  DATA_WIDTH/8  byte enables (sb/sh/sw)
- data_rdata_o  out  DATA_WIDTH  read data
- data_valid_o  out  1  one-cycle completion pulse for data
- stallreq_if_o  out  1  fetch stall request
- stallreq_mem_o  out  1  MEM-stage stall request
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  ADDR_WIDTH  bus address
- bus_wdata_o  out  DATA_WIDTH  bus write data
- bus_be_o  out  DATA_WIDTH/8  bus byte enables; all ones for fetch
- bus_ack_i  in  1  slave completion pulse
- bus_rdata_i  in  DATA_WIDTH  slave read data, valid with bus_ack_i
- err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, last_grant = INST, timeout counter 0.
- States: IDLE, GRANT_D, GRANT_I, RESP.
- IDLE arbitration:
  - Both ce high: grant the port not equal to last_grant (round-robin).
  - One ce high: grant that port.
  - Next state is GRANT_D or GRANT_I.
  - On the transition, latch request fields into bus_*_o registers and set last_grant.
- GRANT_x:
  - bus_req_o = 1; address, data, enables and we stay stable.
  - Counter increments each cycle.
- Acknowledge: when bus_ack_i = 1 in GRANT_x:
  - Capture bus_rdata_i into inst_o or data_rdata_o; a data write loads 0 into data_rdata_o.
  - Go to RESP and drop bus_req_o the next cycle.
- Timeout: counter reaches TIMEOUT_CYCLES without ack (TIMEOUT_CYCLES != 0):
  - Abort and go to RESP.
  - The response register loads 0.
  - err_o pulses in the RESP cycle.
- RESP (exactly one cycle):
  - The granted port's valid pulses; no new grant in this cycle, so a held ce is never re-issued.
  - Next state IDLE, counter cleared.
- Latency:
  - Minimum 3 cycles from ce rise to valid: IDLE, GRANT with ack in its first cycle, RESP.
  - Each slave wait cycle adds 1.
- Stall requests (combinational):
  - stallreq_if_o = inst_ce_i & ~inst_valid_o.
  - stallreq_mem_o = data_ce_i & ~data_valid_o.
- A request dropped while granted is still completed on the bus, but its response is not delivered as valid.
- Writes:
  - bus_be_o = data_be_i.
  - Reads issue data_be_i unchanged; the MEM stage does sign/zero extension.
- Ack in IDLE or RESP is ignored.
- Starvation bound: with both ports requesting continuously, grants alternate D, I, D, I.
- Reset mid-transaction drops bus_req_o immediately (asynchronous); the slave must tolerate an abandoned request.

Decomposition:
- Shared package core_bus_pkg holds:
  - enum arb_state_t {IDLE, GRANT_D, GRANT_I, RESP}
  - enum grant_t {GNT_INST, GNT_DATA}
  - constant BE_ALL = all ones of width DATA_WIDTH/8
- One sub-module, bus_timeout_cnt:
  - Parametrised by TIMEOUT_CYCLES and CNT_WIDTH.
  - Inputs: clear, enable. Output: expired.
  - Tied off to expired = 0 when TIMEOUT_CYCLES = 0.

Test Plan:
- Fetch only, ack on first GRANT cycle: inst_ce_i=1, inst_addr_i=0x100, bus_rdata_i=0x00000013.
  - bus_req_o high 1 cycle with bus_addr_o=0x100, bus_be_o=0xF.
  - inst_valid_o pulses 3 cycles after ce, inst_o=0x13.
  - stallreq_if_o high for the 2 preceding cycles.
- Byte store with 2 wait states: data_we_i=1, data_addr_i=0x2003, data_wdata_i=0x000000AB, data_be_i=0x8.
  - bus_be_o=0x8 held for 3 grant cycles.
  - data_valid_o pulses 5 cycles after ce, data_rdata_o=0.
- Simultaneous fetch and load after reset (last_grant=INST):
  - Data is granted first, then fetch.
  - Both ports continuously requesting yields the grant sequence D, I, D, I.
- Timeout: TIMEOUT_CYCLES=4, slave never acks a load.
  - bus_req_o high exactly 4 cycles.
  - RESP shows data_valid_o=1, err_o=1, data_rdata_o=0; back to IDLE.
- Reset asserted during GRANT_D: bus_req_o and all outputs go 0 asynchronously; state IDLE.
  - After release with inst_ce_i=1, the first grant is data if data_ce_i=1, otherwise fetch.
- Stray bus_ack_i in IDLE and in RESP: no valid pulse, no state change, outputs unchanged.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and constants for the single-port memory bus arbiter.
package core_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_D,
        GRANT_I,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_INST,
        GNT_DATA
    } grant_t;

    // Wide enough for any supported data width; the top slices what it needs.
    localparam int                    BE_MAX_W = 16;
    localparam logic [BE_MAX_W-1:0]   BE_ALL   = '1;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts cycles spent waiting in a grant state; flags expiry on the last
// permitted wait cycle so the grant lasts exactly TIMEOUT_CYCLES cycles.
module bus_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expired_o = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_WIDTH-1:0] L_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

            logic [CNT_WIDTH-1:0] r_cnt;

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (clear_i) begin
                    r_cnt <= '0;
                end else if (enable_i) begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end

            assign expired_o = enable_i & (r_cnt == L_LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one request/acknowledge memory bus between the
// instruction-fetch port and the MEM-stage data port, with registered responses.
module mem_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    inst_ce_i,
    input  logic [ADDR_WIDTH-1:0]   inst_addr_i,
    output logic [DATA_WIDTH-1:0]   inst_o,
    output logic                    inst_valid_o,
    input  logic                    data_ce_i,
    input  logic                    data_we_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_valid_o,
    output logic                    stallreq_if_o,
    output logic                    stallreq_mem_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    input  logic                    bus_ack_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    output logic                    err_o
);

    localparam int              BE_W     = DATA_WIDTH / 8;
    localparam logic [BE_W-1:0] L_BE_ALL = BE_ALL[BE_W-1:0];

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    grant_t                 r_last_grant;
    logic                   r_bus_req;
    logic                   r_bus_we;
    logic [ADDR_WIDTH-1:0]  r_bus_addr;
    logic [DATA_WIDTH-1:0]  r_bus_wdata;
    logic [BE_W-1:0]        r_bus_be;
    logic [DATA_WIDTH-1:0]  r_inst;
    logic [DATA_WIDTH-1:0]  r_data_rdata;
    logic                   r_err;

    logic w_in_grant;
    logic w_grant_d;
    logic w_expired;
    logic w_done;

    assign w_in_grant = (r_state == GRANT_D) || (r_state == GRANT_I);
    // Data wins a tie only when fetch was served last.
    assign w_grant_d  = data_ce_i & (~inst_ce_i | (r_last_grant == GNT_INST));
    assign w_done     = w_in_grant & (bus_ack_i | w_expired);

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (r_state == RESP),
        .enable_i  (w_in_grant),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaulting next state first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = GRANT_D;
                end else if (inst_ce_i) begin
                    w_next_state = GRANT_I;
                end
            end
            GRANT_D, GRANT_I: begin
                if (w_done) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= GNT_INST;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_be     <= '0;
            r_inst       <= '0;
            r_data_rdata <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_state == IDLE) begin
                if (w_grant_d) begin
                    r_last_grant <= GNT_DATA;
                    r_bus_req    <= 1'b1;
                    r_bus_we     <= data_we_i;
                    r_bus_addr   <= data_addr_i;
                    r_bus_wdata  <= data_wdata_i;
                    r_bus_be     <= data_be_i;
                end else if (inst_ce_i) begin
                    r_last_grant <= GNT_INST;
                    r_bus_req    <= 1'b1;
                    r_bus_we     <= 1'b0;
                    r_bus_addr   <= inst_addr_i;
                    r_bus_wdata  <= '0;
                    r_bus_be     <= L_BE_ALL;
                end
            end
            if (w_done) begin
                r_bus_req <= 1'b0;
                r_err     <= ~bus_ack_i;
                // A timeout or a completed write returns zero to the port.
                if (r_state == GRANT_I) begin
                    r_inst <= bus_ack_i ? bus_rdata_i : '0;
                end else begin
                    r_data_rdata <= (bus_ack_i && !r_bus_we) ? bus_rdata_i : '0;
                end
            end
        end
    end

    // Valid is gated by the live request so a port that gave up gets no pulse.
    assign inst_valid_o   = (r_state == RESP) && (r_last_grant == GNT_INST) && inst_ce_i;
    assign data_valid_o   = (r_state == RESP) && (r_last_grant == GNT_DATA) && data_ce_i;
    assign stallreq_if_o  = inst_ce_i & ~inst_valid_o;
    assign stallreq_mem_o = data_ce_i & ~data_valid_o;

    assign inst_o       = r_inst;
    assign data_rdata_o = r_data_rdata;
    assign bus_req_o    = r_bus_req;
    assign bus_we_o     = r_bus_we;
    assign bus_addr_o   = r_bus_addr;
    assign bus_wdata_o  = r_bus_wdata;
    assign bus_be_o     = r_bus_be;
    assign err_o        = r_err;

endmodule
